// File: rtl/my_accumulator_16.sv
// Batch accumulator: sums a stream of 16-bit words with a ripple adder and
// hands the total, term count and sticky signed overflow to a sink via valid/ready.

module my_adder_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [16:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[16];

endmodule

module my_accumulator_16 #(
  parameter int COUNT_WIDTH = 8,
  parameter int MAX_TERMS   = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_data,
  input  logic                   clear,
  input  logic                   dump,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_data,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   out_ovf
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [COUNT_WIDTH-1:0] MAX_CNT = COUNT_WIDTH'(MAX_TERMS);

  state_t                   state;
  logic [15:0]              acc;
  logic [COUNT_WIDTH-1:0]   count;
  logic                     ovf;

  logic [15:0]              add_a;
  logic [15:0]              sum;
  logic                     cout;
  logic                     v;
  logic                     accept;
  logic [COUNT_WIDTH-1:0]   next_count;

  // A clear in the same cycle as an accept starts a fresh batch, so the adder
  // sees zero instead of the old total.
  assign add_a = clear ? '0 : acc;

  my_adder_16 u_adder (
    .a    (add_a),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Signed overflow: carry into the MSB differs from carry out of it.
  assign v = cout ^ add_a[15] ^ in_data[15] ^ sum[15];

  assign in_ready   = (state == ACC) && rst_n;
  assign accept     = in_valid && in_ready;
  assign next_count = clear ? COUNT_WIDTH'(1) : count + COUNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc   <= sum;
            count <= next_count;
            ovf   <= clear ? 1'b0 : (ovf | v);
          end else if (clear) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
          end
          if (dump || (accept && next_count == MAX_CNT))
            state <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            state <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

  assign out_valid = (state == HOLD);
  assign out_data  = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_my_accumulator_16.sv
// Directed bench for my_accumulator_16: table of batches plus hand-written
// sequences for auto-dump, clear, dump-with-accept, HOLD stability and reset.

module tb_my_accumulator_16;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          clear;
  logic          dump;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic [CW-1:0] out_count;
  logic          out_ovf;

  int checks = 0;
  int errors = 0;

  my_accumulator_16 #(.COUNT_WIDTH(CW), .MAX_TERMS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .clear     (clear),
    .dump      (dump),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] terms [3];
    int          n;
    logic [15:0] exp_data;
    logic [7:0]  exp_count;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_hold(input string name, input logic [15:0] d, input logic [7:0] c, input logic o);
    checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({name, "_ready"}, 32'(in_ready), 32'd0);
    checkOutput({name, "_data"}, 32'(out_data), 32'(d));
    checkOutput({name, "_count"}, 32'(out_count), 32'(c));
    checkOutput({name, "_ovf"}, 32'(out_ovf), 32'(o));
  endtask

  task automatic feed(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_dump();
    dump = 1'b1;
    tick();
    dump = 1'b0;
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({name, "_hs_valid"}, 32'(out_valid), 32'd0);
    checkOutput({name, "_hs_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    string name;
    name = $sformatf("vec%0d", idx);
    for (int i = 0; i < v.n; i++) feed(v.terms[i]);
    do_dump();
    check_hold(name, v.exp_data, v.exp_count, v.exp_ovf);
    handshake(name);
  endtask

  function automatic vec_t mk(input logic [15:0] t0, input logic [15:0] t1, input logic [15:0] t2,
                              input int n, input logic [15:0] d, input logic [7:0] c, input logic o);
    vec_t r;
    r.terms[0] = t0; r.terms[1] = t1; r.terms[2] = t2;
    r.n = n; r.exp_data = d; r.exp_count = c; r.exp_ovf = o;
    return r;
  endfunction

  initial begin
    vecs[0] = mk(16'h0003, 16'h0004, 16'h0005, 3, 16'h000C, 8'd3, 1'b0);
    vecs[1] = mk(16'h7FFF, 16'h0001, 16'h0000, 2, 16'h8000, 8'd2, 1'b1);
    vecs[2] = mk(16'hFFFF, 16'h0001, 16'h0000, 2, 16'h0000, 8'd2, 1'b0);
    vecs[3] = mk(16'h8000, 16'h8000, 16'h0000, 2, 16'h0000, 8'd2, 1'b1);
    vecs[4] = mk(16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 8'd0, 1'b0);
    vecs[5] = mk(16'h1234, 16'h1111, 16'h0001, 3, 16'h2346, 8'd3, 1'b0);
    vecs[6] = mk(16'h7FFF, 16'h0001, 16'hFFFF, 3, 16'h7FFF, 8'd3, 1'b1);

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0; dump = 1'b0; out_ready = 1'b0;
    #2;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("post_rst_out_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

    // Auto-dump at MAX_TERMS=4 with a continuous stream; fifth term stalls.
    in_valid = 1'b1; in_data = 16'h0010;
    repeat (4) tick();
    check_hold("auto", 16'h0040, 8'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_hold($sformatf("stall%0d", i), 16'h0040, 8'd4, 1'b0);
    end
    handshake("auto");
    tick();
    in_valid = 1'b0;
    do_dump();
    check_hold("fifth", 16'h0010, 8'd1, 1'b0);
    handshake("fifth");

    // clear with accept restarts the batch and drops sticky overflow.
    feed(16'h7FFF);
    feed(16'h0001);
    clear = 1'b1; in_valid = 1'b1; in_data = 16'h0002;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    do_dump();
    check_hold("clr_acc", 16'h0002, 8'd1, 1'b0);
    handshake("clr_acc");

    // clear without accept, then an empty dump.
    feed(16'h0100);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    do_dump();
    check_hold("clr_only", 16'h0000, 8'd0, 1'b0);
    handshake("clr_only");

    // clear + accept + dump in one cycle emits the new term alone.
    feed(16'h0300);
    clear = 1'b1; dump = 1'b1; in_valid = 1'b1; in_data = 16'h0055;
    tick();
    clear = 1'b0; dump = 1'b0; in_valid = 1'b0;
    check_hold("clr_dump", 16'h0055, 8'd1, 1'b0);
    handshake("clr_dump");

    // Accept in the dump cycle is included; clear/dump/data ignored in HOLD.
    feed(16'h0001);
    dump = 1'b1; in_valid = 1'b1; in_data = 16'h0009;
    tick();
    dump = 1'b0; in_valid = 1'b0;
    check_hold("dump_acc", 16'h000A, 8'd2, 1'b0);
    dump = 1'b1; clear = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF;
    repeat (2) tick();
    dump = 1'b0; clear = 1'b0; in_valid = 1'b0;
    check_hold("hold_ign", 16'h000A, 8'd2, 1'b0);
    handshake("hold_ign");

    // Asynchronous reset mid-batch.
    feed(16'h0005);
    feed(16'h0005);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    do_dump();
    check_hold("rst_mid_dump", 16'h0000, 8'd0, 1'b0);
    handshake("rst_mid");

    // Asynchronous reset during HOLD.
    feed(16'h0007);
    do_dump();
    check_hold("pre_rst_hold", 16'h0007, 8'd1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_hold_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_hold_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("rst_hold_ready2", 32'(in_ready), 32'd1);
    do_dump();
    check_hold("rst_hold_dump", 16'h0000, 8'd0, 1'b0);
    handshake("rst_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
